// File: rtl/ids_host_sequencer.sv
// Purpose  : host-side initiator for the LTE IDS detector; frames NAS words into message SRAM, launches the detector, returns its verdict.
// Latency  : count header written 1 cycle after the last accepted word, dut_valid rises the cycle after; verdict valid 2 cycles after detector done.
// Backpress: in_ready low outside IDLE/LOAD; the verdict is held in RESULT until result_ready.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   in_valid/in_data/in_last/in_ready message word stream (valid/ready)
//   sram_write_*                      message SRAM write port (count at 0, payload from 1)
//   sram_read_address/sram_read_data  message SRAM read port, data one cycle after address
//   dut_valid/dut_ready               detector start request / idle-done status
//   result_valid/_code/_err/_ready    verdict output (valid/ready)
module ids_host_sequencer #(
    parameter int MAX_WORDS  = 1024,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  sram_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_write_address,
    output logic [31:0]           sram_write_data,
    output logic [ADDR_WIDTH-1:0] sram_read_address,
    input  logic [31:0]           sram_read_data,
    output logic                  dut_valid,
    input  logic                  dut_ready,
    output logic                  result_valid,
    output logic [7:0]            result_code,
    output logic                  result_err,
    input  logic                  result_ready
);
    localparam int                    TW       = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT  = ADDR_WIDTH'(MAX_WORDS);
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HDR, S_START, S_RUN, S_RD_ADDR, S_RD_DATA, S_RESULT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_count;
    logic                  r_ovf;
    logic                  r_alive;
    logic [TW-1:0]         r_tmo;
    logic [7:0]            r_code;
    logic                  r_err;

    logic                  w_loading;
    logic                  w_accept;
    logic                  w_store;
    logic                  w_hdr;
    logic                  w_waiting;
    logic                  w_tmo_hit;
    logic                  w_abort;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_rd_unused;

    // r_alive keeps in_ready low while reset is asserted even though IDLE accepts words.
    assign w_loading   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign in_ready    = r_alive && w_loading;
    assign w_accept    = in_valid && in_ready;
    // Once the frame is full, words are still accepted but dropped.
    assign w_store     = w_accept && (r_count != MAX_CNT);
    assign w_hdr       = (r_state == S_HDR);
    assign w_waiting   = (r_state == S_START) || (r_state == S_RUN);
    // >= so a START exit on the last allowed cycle still times out early in RUN.
    assign w_tmo_hit   = w_waiting && (r_tmo >= TMO_LAST);
    assign w_next_addr = r_count + ADDR_WIDTH'(1);

    assign sram_write_enable  = w_store || w_hdr;
    assign sram_write_address = w_store ? w_next_addr : '0;
    assign sram_write_data    = w_store ? in_data : (w_hdr ? 32'(r_count) : 32'd0);
    assign sram_read_address  = (r_state == S_RD_ADDR) ? w_next_addr : '0;

    assign dut_valid    = (r_state == S_START);
    assign result_valid = (r_state == S_RESULT);
    assign result_code  = r_code;
    assign result_err   = r_err;

    // Only the low byte of the verdict word carries the attack code.
    assign w_rd_unused = ^sram_read_data[31:8];

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (w_accept) begin
                    w_next = in_last ? S_HDR : S_LOAD;
                end
            end
            S_HDR:   w_next = S_START;
            S_START: begin
                if (!dut_ready) begin
                    w_next = S_RUN;
                end else if (w_tmo_hit) begin
                    w_next  = S_RESULT;
                    w_abort = 1'b1;
                end
            end
            S_RUN: begin
                if (dut_ready) begin
                    w_next = S_RD_ADDR;
                end else if (w_tmo_hit) begin
                    w_next  = S_RESULT;
                    w_abort = 1'b1;
                end
            end
            S_RD_ADDR: w_next = S_RD_DATA;
            S_RD_DATA: w_next = S_RESULT;
            S_RESULT: begin
                if (result_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_tmo   <= '0;
            r_code  <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_store) begin
                r_count <= w_next_addr;
            end
            if (w_accept && !w_store) begin
                r_ovf <= 1'b1;
            end
            if (w_hdr) begin
                r_tmo <= '0;
            end else if (w_waiting) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_abort) begin
                r_code <= 8'hFF;
                r_err  <= 1'b1;
            end else if (r_state == S_RD_DATA) begin
                r_code <= sram_read_data[7:0];
                r_err  <= r_ovf;
            end
            if (result_valid && result_ready) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ids_host_sequencer.sv
// Purpose  : self-checking bench for ids_host_sequencer with an SRAM model, a detector responder and a frame-level reference model.
// Latency  : expected writes, read address, dut_valid length and verdict are derived per frame and compared every negedge.
// Backpress: result_ready is held low for random/directed spans; in_valid is presented with random gaps.
module tb_ids_host_sequencer;
    localparam int AW   = 8;
    localparam int MAXW = 4;
    localparam int TMO  = 50;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_last;
    logic          in_ready;
    logic          sram_write_enable;
    logic [AW-1:0] sram_write_address;
    logic [31:0]   sram_write_data;
    logic [AW-1:0] sram_read_address;
    logic [31:0]   rd_data;
    logic          dut_valid;
    logic          dut_ready;
    logic          result_valid;
    logic [7:0]    result_code;
    logic          result_err;
    logic          result_ready;

    always #5 clk = ~clk;

    ids_host_sequencer #(.MAX_WORDS(MAXW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_last            (in_last),
        .in_ready           (in_ready),
        .sram_write_enable  (sram_write_enable),
        .sram_write_address (sram_write_address),
        .sram_write_data    (sram_write_data),
        .sram_read_address  (sram_read_address),
        .sram_read_data     (rd_data),
        .dut_valid          (dut_valid),
        .dut_ready          (dut_ready),
        .result_valid       (result_valid),
        .result_code        (result_code),
        .result_err         (result_err),
        .result_ready       (result_ready)
    );

    int             tests = 0;
    int             fails = 0;
    logic [31:0]    mem      [0:(1<<AW)-1];
    int             wr_frame [0:(1<<AW)-1];
    int             frame_id = 0;
    logic [AW+31:0] exp_wr_q [$];
    logic           frame_active = 1'b0;
    logic [AW-1:0]  exp_rd_addr;
    logic           exp_timeout;
    logic [7:0]     exp_code;
    logic           exp_err;
    int             exp_dv;
    logic [AW-1:0]  verdict_addr;
    logic [31:0]    verdict_val;
    int             dv_cnt = 0;
    int             last_dv = 0;
    logic [7:0]     last_code = 8'h00;
    logic           last_err = 1'b0;
    logic [AW-1:0]  last_rd = '0;
    int             resp_drop;
    int             resp_run;
    logic           resp_never;
    logic           resp_early;
    logic           resp_busy;
    logic [31:0]    fw [0:15];
    int             fn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM read port: the detector's verdict word sits at verdict_addr.
    always @(posedge clk) begin
        rd_data <= (sram_read_address == verdict_addr) ? verdict_val : mem[sram_read_address];
    end

    // Detector responder.
    initial begin
        dut_ready = 1'b1;
        resp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && resp_early && sram_write_enable && sram_write_address == '0) begin
                resp_busy = 1'b1;
                dut_ready = 1'b0;
                @(negedge clk);
                repeat (resp_run) @(negedge clk);
                dut_ready = 1'b1;
                resp_busy = 1'b0;
            end else if (reset_n && !resp_early && !resp_never && dut_valid) begin
                resp_busy = 1'b1;
                repeat (resp_drop) @(negedge clk);
                dut_ready = 1'b0;
                repeat (resp_run) @(negedge clk);
                dut_ready = 1'b1;
                resp_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare against the frame model.
    initial begin
        logic [AW+31:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                dv_cnt = 0;
            end else if (!frame_active) begin
                check("idle_write", 32'(sram_write_enable), 32'd0);
                check("idle_dut_valid", 32'(dut_valid), 32'd0);
                check("idle_result_valid", 32'(result_valid), 32'd0);
            end else begin
                if (sram_write_enable) begin
                    wr_frame[sram_write_address] = frame_id;
                    mem[sram_write_address] = sram_write_data;
                    check("write_expected", 32'(exp_wr_q.size() > 0), 32'd1);
                    if (exp_wr_q.size() > 0) begin
                        e = exp_wr_q.pop_front();
                        check("write_addr", 32'(sram_write_address), 32'(e[AW+31:32]));
                        check("write_data", sram_write_data, e[31:0]);
                    end
                end
                if (sram_read_address != '0) begin
                    last_rd = sram_read_address;
                    check("read_addr", 32'(sram_read_address), exp_timeout ? 32'd0 : 32'(exp_rd_addr));
                end
                if (dut_valid) begin
                    dv_cnt++;
                end else if (dv_cnt != 0) begin
                    last_dv = dv_cnt;
                    check("dut_valid_len", dv_cnt, exp_dv);
                    dv_cnt = 0;
                end
                if (result_valid) begin
                    last_code = result_code;
                    last_err  = result_err;
                    check("result_code", 32'(result_code), 32'(exp_code));
                    check("result_err", 32'(result_err), 32'(exp_err));
                end
                if (dut_valid || result_valid) begin
                    check("in_ready_busy", 32'(in_ready), 32'd0);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!acc && n < 200);
        check("word_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic setup_frame();
        int stored;
        frame_id++;
        stored = (fn > MAXW) ? MAXW : fn;
        exp_wr_q.delete();
        for (int i = 0; i < stored; i++) exp_wr_q.push_back({AW'(i + 1), fw[i]});
        exp_wr_q.push_back({AW'(0), 32'(stored)});
        exp_rd_addr  = AW'(stored + 1);
        verdict_addr = AW'(stored + 1);
        exp_timeout  = resp_never;
        exp_code     = resp_never ? 8'hFF : verdict_val[7:0];
        exp_err      = resp_never || (fn > MAXW);
        exp_dv       = resp_never ? TMO : (resp_early ? 1 : resp_drop + 1);
        frame_active = 1'b1;
    endtask

    task automatic send_words();
        for (int i = 0; i < fn; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_word(fw[i], i == fn - 1);
        end
    endtask

    task automatic wait_result(output logic ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result_valid && n < 400);
        ok = result_valid;
        check("result_arrived", 32'(result_valid), 32'd1);
    endtask

    task automatic run_frame(input int hold);
        logic ok;
        int   stored;
        int   top;
        setup_frame();
        send_words();
        wait_result(ok);
        if (ok) begin
            repeat (hold) @(posedge clk);
            #1 result_ready = 1'b1;
            @(posedge clk);
            #1 result_ready = 1'b0;
            @(negedge clk);
            check("result_released", 32'(result_valid), 32'd0);
            check("idle_in_ready", 32'(in_ready), 32'd1);
        end
        frame_active = 1'b0;
        stored = (fn > MAXW) ? MAXW : fn;
        top = (fn > stored) ? fn : stored + 1;
        check("writes_drained", 32'(exp_wr_q.size()), 32'd0);
        check("header_word", mem[0], 32'(stored));
        for (int i = 0; i < stored; i++) check("payload_word", mem[i + 1], fw[i]);
        for (int a = stored + 1; a <= top; a++) check("no_write_past_end", 32'(wr_frame[a] == frame_id), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_abort(input int phase);
        logic ok;
        int   n;
        fn = 2;
        fw[0] = $urandom;
        fw[1] = $urandom;
        resp_never = 1'b0;
        resp_early = 1'b0;
        resp_drop = 6;
        resp_run = 12;
        verdict_val = $urandom;
        setup_frame();
        send_words();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dut_valid && n < 50);
        check("abort_start_seen", 32'(dut_valid), 32'd1);
        if (phase == 0) begin
            repeat (2) @(negedge clk);
        end else if (phase == 1) begin
            n = 0;
            while (dut_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            repeat (3) @(negedge clk);
        end else begin
            wait_result(ok);
        end
        #2 reset_n = 1'b0;
        #1;
        check("abort_dut_valid", 32'(dut_valid), 32'd0);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_write_en", 32'(sram_write_enable), 32'd0);
        frame_active = 1'b0;
        exp_wr_q.delete();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        n = 0;
        while (resp_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("responder_idle", 32'(resp_busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_data = 32'd0;
        in_last = 1'b0;
        result_ready = 1'b0;
        resp_drop = 0;
        resp_run = 1;
        resp_never = 1'b0;
        resp_early = 1'b0;
        verdict_val = 32'd0;
        verdict_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_dut_valid", 32'(dut_valid), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_write_en", 32'(sram_write_enable), 32'd0);
        check("rst_write_addr", 32'(sram_write_address), 32'd0);
        check("rst_write_data", sram_write_data, 32'd0);
        check("rst_read_addr", 32'(sram_read_address), 32'd0);
        check("rst_code", 32'(result_code), 32'd0);
        check("rst_err", 32'(result_err), 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 3-word frame, verdict 02 at address 4.
        fn = 3; fw[0] = 32'hA1; fw[1] = 32'hB2; fw[2] = 32'hC3;
        resp_drop = 2; resp_run = 5; verdict_val = 32'h0000_0002;
        run_frame(0);
        check("lit3_hdr", mem[0], 32'd3);
        check("lit3_w1", mem[1], 32'hA1);
        check("lit3_w3", mem[3], 32'hC3);
        check("lit3_rd", 32'(last_rd), 32'd4);
        check("lit3_code", 32'(last_code), 32'h02);
        check("lit3_err", 32'(last_err), 32'd0);
        check("lit3_dv_len", last_dv, 32'd3);

        // Single word with in_last; detector already busy in the first START cycle.
        fn = 1; fw[0] = 32'hDEADBEEF;
        resp_early = 1'b1; resp_run = 4; verdict_val = 32'h0000_0001;
        run_frame(1);
        resp_early = 1'b0;
        check("lit1_hdr", mem[0], 32'd1);
        check("lit1_w1", mem[1], 32'hDEADBEEF);
        check("lit1_code", 32'(last_code), 32'h01);
        check("lit1_dv_len", last_dv, 32'd1);

        // Overflow: 6 words into a 4-word frame.
        fn = 6;
        for (int i = 0; i < 6; i++) fw[i] = 32'h11 * (i + 1);
        resp_drop = 1; resp_run = 3; verdict_val = 32'h0000_0003;
        run_frame(2);
        check("litov_hdr", mem[0], 32'd4);
        check("litov_rd", 32'(last_rd), 32'd5);
        check("litov_err", 32'(last_err), 32'd1);
        check("litov_code", 32'(last_code), 32'h03);

        // Timeout: detector never leaves idle.
        fn = 2; fw[0] = 32'h1234_5678; fw[1] = 32'h9ABC_DEF0;
        resp_never = 1'b1;
        run_frame(0);
        resp_never = 1'b0;
        check("littmo_code", 32'(last_code), 32'hFF);
        check("littmo_err", 32'(last_err), 32'd1);
        check("littmo_dv_len", last_dv, 32'd50);

        // Backpressure and out-of-range verdict passthrough.
        fn = 2; fw[0] = 32'hCAFE_0001; fw[1] = 32'hCAFE_0002;
        resp_drop = 3; resp_run = 6; verdict_val = 32'hABCD_1277;
        run_frame(10);
        check("litbp_code", 32'(last_code), 32'h77);

        // Asynchronous reset in START, RUN and RESULT.
        for (int p = 0; p < 3; p++) reset_abort(p);
        fn = 2; fw[0] = 32'h5555_0000; fw[1] = 32'h5555_0001;
        resp_drop = 0; resp_run = 2; verdict_val = 32'h0000_0004;
        run_frame(0);
        check("litrst_hdr", mem[0], 32'd2);
        check("litrst_code", 32'(last_code), 32'h04);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            fn = $urandom_range(1, 7);
            for (int i = 0; i < fn; i++) fw[i] = $urandom;
            m = $urandom_range(0, 9);
            resp_never = (m == 0);
            resp_early = (m == 1) || (m == 2);
            resp_drop = $urandom_range(0, 6);
            resp_run = $urandom_range(1, 15);
            verdict_val = $urandom;
            if ($urandom_range(0, 1) == 1) verdict_val[7:0] = 8'($urandom_range(0, 4));
            run_frame($urandom_range(0, 4));
        end
        resp_never = 1'b0;
        resp_early = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
